ex_stage: RTL and testbench
===========================

# ex_stage

Execute pipeline stage of the RV32I core. It accepts one decoded instruction per cycle from decode and selects ALU operands, with optional forwarding from MEM/WB. It drives the existing 32-bit ALU, resolves branches and jumps, and holds the result in a registered EX/MEM output slot under a valid/ready handshake.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  decode presents an instruction.
- in_ready  output  1  stage accepts this cycle.
- in_pc  input  32  instruction PC.
- in_rs1_val, in_rs2_val  input  32 each  register-file operands.
- in_imm  input  32  sign-extended immediate.
- in_rs1, in_rs2, in_rd  input  5 each  register addresses.
- in_alu_op  input  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND; others produce 0.
- in_a_pc  input  1  operand A = in_pc instead of rs1.
- in_b_imm  input  1  operand B = in_imm instead of rs2.
- in_reg_write  input  1  instruction writes rd.
- in_br_type  input  3  0 none, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU, 7 JAL/JALR.
- in_jalr  input  1  target base is rs1, not pc.
- flush  input  1  kill slot and refuse input this cycle.
- fwd_mem_we, fwd_mem_rd, fwd_mem_data  input  1/5/32  MEM-stage bypass.
- fwd_wb_we, fwd_wb_rd, fwd_wb_data  input  1/5/32  WB-stage bypass.
- out_valid  output  1  slot holds a result.
- out_ready  input  1  MEM consumes the slot.
- out_result  output  32  ALU result, or pc+4 for br_type 7.
- out_store_data  output  32  forwarded rs2 value.
- out_rd  output  5  destination register.
- out_reg_write  output  1  write enable; forced 0 when rd = 0.
- redirect_valid  output  1  taken branch/jump, one-cycle pulse.
- redirect_pc  output  32  fetch target.

## Operation
- Accept = in_valid & in_ready.
- in_ready = !flush & (!out_valid | out_ready).
- Operand A = in_a_pc ? in_pc : fwdA. Operand B = in_b_imm ? in_imm : fwdB.
- Forwarding for each source:
  - MEM match (we, rd ≠ 0, rd = rs) takes priority.
  - Otherwise WB match.
  - Otherwise register-file value.
- Branch compare always uses fwdA/fwdB, independent of the ALU op:
  - EQ, NE: equality.
  - LT, GE: signed compare.
  - LTU, GEU: unsigned compare.
  - br_type 7 is always taken.
- Target:
  - pc + imm.
  - JALR: (fwdA + imm) & ~1.
  - All arithmetic mod 2^32.
- br_type 7 result = pc + 4. Wrap-around: pc 0xFFFFFFFC gives result 0.
- Slot register states: EMPTY, FULL.
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on out_ready without accept.
  - FULL stays FULL (reloaded) on out_ready with accept.
  - Any state -> EMPTY on flush.
- Flush has priority over accept and over out_ready. A flushed result is never presented.

## Timing
- Latency: 1 cycle. Accepted at edge N, out_* valid after edge N.
- Throughput: 1 per cycle while out_ready stays high.
- Backpressure: when out_valid & !out_ready, all out_* hold stable and in_ready = 0.
- redirect_valid:
  - Registered.
  - High for exactly the cycle after a taken branch is accepted.
  - Never re-asserts while the slot stalls.
  - Cleared by flush in the same edge.
- Reset values: out_valid 0, out_result 0, out_store_data 0, out_rd 0, out_reg_write 0, redirect_valid 0, redirect_pc 0.
- Reset mid-stall discards the slot with no output pulse.
- Forwarding is combinational on same-cycle fwd_* inputs. No internal bypass from the stage's own slot; MEM drives fwd_mem_* from it.

## Configuration
- EX_FORWARDING_EN defined: the MEM/WB bypass is built as described.
- EX_FORWARDING_EN undefined:
  - fwd_* ports remain but are ignored.
  - fwdA = in_rs1_val and fwdB = in_rs2_val.
  - Decode is responsible for stalling on hazards.

## Structure
- Shared package core_pkg holds:
  - alu_op_e enum (values 0–9 above).
  - br_type_e enum.
  - XLEN constant.
  - ex_mem_t struct (result, store_data, rd, reg_write).
- Sub-module ex_forward: per-operand priority mux. It is instantiated twice, and compiled as a passthrough without EX_FORWARDING_EN.
- The ALU is instantiated unchanged.

## Test plan
- ADD, rs1=5, rs2=7, b_imm=0 -> one cycle later out_valid=1, out_result=12, redirect_valid=0.
- SRA, rs1=0x80000000, imm=4, b_imm=1 -> out_result 0xF8000000. SLTU with rs1=1, rs2=0xFFFFFFFF -> 1.
- EX_FORWARDING_EN:
  - rs1=3, fwd_mem (we, rd=3, 0x10), fwd_wb (rd=3, 0x20), rs1_val=0x30, ADDI imm=1 -> result 0x11.
  - Same with rd=0 -> result 0x31.
- BLT, pc=0x100, rs1=-1, rs2=0, imm=0x20 -> redirect_valid pulse, redirect_pc 0x120. BLTU with the same operands -> no redirect.
- JALR, pc=0x40, rs1=0x1001, imm=2 -> out_result 0x44, redirect_pc 0x1002. Hold out_ready=0 for 3 cycles -> outputs stable, in_ready=0, single redirect pulse.
- Stall with the slot FULL, then assert flush with in_valid=1 -> out_valid 0 next cycle, input not accepted. Assert rst mid-stream -> all outputs reset asynchronously.

Source files
------------

// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg -- shared RV32I core types.
//   XLEN      : datapath width (32 only).
//   alu_op_e  : ALU operation select (encodings 0..9, anything else -> 0).
//   br_type_e : branch/jump class resolved in the execute stage.
//   ex_mem_t  : payload carried in the EX/MEM slot.
// ---------------------------------------------------------------------------
package core_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_EQ   = 3'd1,
    BR_NE   = 3'd2,
    BR_LT   = 3'd3,
    BR_GE   = 3'd4,
    BR_LTU  = 3'd5,
    BR_GEU  = 3'd6,
    BR_JUMP = 3'd7
  } br_type_e;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] store_data;
    logic [4:0]      rd;
    logic            reg_write;
  } ex_mem_t;

endpackage

// File: rtl/ex_stage_if.sv
// ---------------------------------------------------------------------------
// ex_stage_if -- bundle of every execute-stage signal except clk/rst.
//   Decode side : in_valid/in_ready handshake plus the decoded instruction.
//   Bypass side : fwd_mem_* and fwd_wb_* register-write snoops.
//   MEM side    : out_valid/out_ready handshake plus the EX/MEM payload.
//   Fetch side  : redirect_valid/redirect_pc.
// modport master : the surroundings (decode, MEM, WB, fetch).
// modport slave  : the execute stage itself.
// ---------------------------------------------------------------------------
interface ex_stage_if;
  import core_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_rs1_val;
  logic [XLEN-1:0] in_rs2_val;
  logic [XLEN-1:0] in_imm;
  logic [4:0]      in_rs1;
  logic [4:0]      in_rs2;
  logic [4:0]      in_rd;
  logic [3:0]      in_alu_op;
  logic            in_a_pc;
  logic            in_b_imm;
  logic            in_reg_write;
  logic [2:0]      in_br_type;
  logic            in_jalr;
  logic            flush;
  logic            fwd_mem_we;
  logic [4:0]      fwd_mem_rd;
  logic [XLEN-1:0] fwd_mem_data;
  logic            fwd_wb_we;
  logic [4:0]      fwd_wb_rd;
  logic [XLEN-1:0] fwd_wb_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic [XLEN-1:0] out_store_data;
  logic [4:0]      out_rd;
  logic            out_reg_write;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output in_valid, in_pc, in_rs1_val, in_rs2_val, in_imm,
           in_rs1, in_rs2, in_rd, in_alu_op, in_a_pc, in_b_imm,
           in_reg_write, in_br_type, in_jalr, flush,
           fwd_mem_we, fwd_mem_rd, fwd_mem_data,
           fwd_wb_we, fwd_wb_rd, fwd_wb_data, out_ready,
    input  in_ready, out_valid, out_result, out_store_data,
           out_rd, out_reg_write, redirect_valid, redirect_pc
  );

  modport slave (
    input  in_valid, in_pc, in_rs1_val, in_rs2_val, in_imm,
           in_rs1, in_rs2, in_rd, in_alu_op, in_a_pc, in_b_imm,
           in_reg_write, in_br_type, in_jalr, flush,
           fwd_mem_we, fwd_mem_rd, fwd_mem_data,
           fwd_wb_we, fwd_wb_rd, fwd_wb_data, out_ready,
    output in_ready, out_valid, out_result, out_store_data,
           out_rd, out_reg_write, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu -- 32-bit RV32I integer ALU, purely combinational.
//   op : alu_op_e operation select (undefined encodings give 0)
//   a  : operand A
//   b  : operand B (shift amount is b[4:0])
//   y  : result
// ---------------------------------------------------------------------------
module alu
  import core_pkg::*;
(
  input  alu_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << shamt;
      ALU_SLT:  y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: y = {{(XLEN-1){1'b0}}, a < b};
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> shamt;
      ALU_SRA:  y = $unsigned($signed(a) >>> shamt);
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/ex_forward.sv
// ---------------------------------------------------------------------------
// ex_forward -- bypass mux for one source operand.
//   rs                         : source register address
//   rf_val                     : register-file value for rs
//   mem_we/mem_rd/mem_data     : MEM-stage pending write (highest priority)
//   wb_we/wb_rd/wb_data        : WB-stage pending write
//   val                        : forwarded operand value
// Build option: EX_FORWARDING_EN. When undefined, val is rf_val and the
// bypass inputs are ignored (decode must stall on hazards instead).
// ---------------------------------------------------------------------------
module ex_forward
  import core_pkg::*;
(
  input  logic [4:0]      rs,
  input  logic [XLEN-1:0] rf_val,
  input  logic            mem_we,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] val
);

`ifdef EX_FORWARDING_EN
  // x0 is hardwired to zero, so a pending write to it must never bypass.
  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_we && (mem_rd == rs) && (rs != 5'd0);
  assign wb_hit  = wb_we  && (wb_rd  == rs) && (rs != 5'd0);

  always_comb begin
    val = rf_val;
    if (mem_hit) begin
      val = mem_data;
    end else if (wb_hit) begin
      val = wb_data;
    end
  end
`else
  // Bypass inputs are tied into a reduction sink so they stay connected
  // in this build without affecting the result.
  logic unused_fwd;
  assign unused_fwd = ^{rs, mem_we, mem_rd, mem_data, wb_we, wb_rd, wb_data};
  assign val = rf_val;
`endif

endmodule

// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage -- RV32I execute stage.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : ex_stage_if.slave
//     decode handshake in_valid/in_ready with the decoded instruction,
//     MEM/WB bypass snoops fwd_*, registered EX/MEM slot out_* with the
//     out_valid/out_ready handshake, and a one-cycle redirect to fetch.
// Build option: EX_FORWARDING_EN enables the MEM/WB operand bypass
// (see ex_forward); without it operands come straight from the register file.
// The slot is a one-deep register (EMPTY/FULL); flush empties it and blocks
// acceptance in the same cycle.
// ---------------------------------------------------------------------------
module ex_stage #(
  parameter int XLEN = 32
) (
  input logic      clk,
  input logic      rst,
  ex_stage_if.slave bus
);
  import core_pkg::*;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // -------------------------------------------------------------------------
  // Operand forwarding: index 0 is rs1, index 1 is rs2.
  // -------------------------------------------------------------------------
  logic [4:0]      src_rs  [2];
  logic [XLEN-1:0] src_rf  [2];
  logic [XLEN-1:0] src_fwd [2];

  assign src_rs[0] = bus.in_rs1;
  assign src_rs[1] = bus.in_rs2;
  assign src_rf[0] = bus.in_rs1_val;
  assign src_rf[1] = bus.in_rs2_val;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      ex_forward u_fwd (
        .rs       (src_rs[gi]),
        .rf_val   (src_rf[gi]),
        .mem_we   (bus.fwd_mem_we),
        .mem_rd   (bus.fwd_mem_rd),
        .mem_data (bus.fwd_mem_data),
        .wb_we    (bus.fwd_wb_we),
        .wb_rd    (bus.fwd_wb_rd),
        .wb_data  (bus.fwd_wb_data),
        .val      (src_fwd[gi])
      );
    end
  endgenerate

  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;
  assign fwd_a = src_fwd[0];
  assign fwd_b = src_fwd[1];

  // -------------------------------------------------------------------------
  // ALU
  // -------------------------------------------------------------------------
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_y;

  assign alu_a = bus.in_a_pc  ? bus.in_pc  : fwd_a;
  assign alu_b = bus.in_b_imm ? bus.in_imm : fwd_b;

  alu u_alu (
    .op (alu_op_e'(bus.in_alu_op)),
    .a  (alu_a),
    .b  (alu_b),
    .y  (alu_y)
  );

  // -------------------------------------------------------------------------
  // Branch resolution. The comparison always uses the forwarded register
  // values, independent of what the ALU is computing.
  // -------------------------------------------------------------------------
  logic            br_taken;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] br_target;
  logic            is_jump;

  assign is_jump  = (br_type_e'(bus.in_br_type) == BR_JUMP);
  assign jalr_sum = fwd_a + bus.in_imm;
  assign br_target = bus.in_jalr ? {jalr_sum[XLEN-1:1], 1'b0}
                                 : bus.in_pc + bus.in_imm;

  always_comb begin
    br_taken = 1'b0;
    case (br_type_e'(bus.in_br_type))
      BR_NONE: br_taken = 1'b0;
      BR_EQ:   br_taken = (fwd_a == fwd_b);
      BR_NE:   br_taken = (fwd_a != fwd_b);
      BR_LT:   br_taken = ($signed(fwd_a) <  $signed(fwd_b));
      BR_GE:   br_taken = ($signed(fwd_a) >= $signed(fwd_b));
      BR_LTU:  br_taken = (fwd_a <  fwd_b);
      BR_GEU:  br_taken = (fwd_a >= fwd_b);
      BR_JUMP: br_taken = 1'b1;
      default: br_taken = 1'b0;
    endcase
  end

  // Link value for jumps; wraps naturally modulo 2^32.
  logic [XLEN-1:0] exec_result;
  assign exec_result = is_jump ? bus.in_pc + 32'd4 : alu_y;

  ex_mem_t exec_slot;
  assign exec_slot.result     = exec_result;
  assign exec_slot.store_data = fwd_b;
  assign exec_slot.rd         = bus.in_rd;
  assign exec_slot.reg_write  = bus.in_reg_write && (bus.in_rd != 5'd0);

  // -------------------------------------------------------------------------
  // Slot control
  // -------------------------------------------------------------------------
  slot_state_e     state_reg, state_next;
  ex_mem_t         slot_reg, slot_next;
  logic            redirect_valid_reg, redirect_valid_next;
  logic [XLEN-1:0] redirect_pc_reg, redirect_pc_next;
  logic            in_ready;
  logic            accept;

  // flush forces in_ready low, so it also blocks acceptance.
  assign in_ready = !bus.flush && (state_reg == SLOT_EMPTY || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    state_next          = state_reg;
    slot_next           = slot_reg;
    redirect_valid_next = 1'b0;
    redirect_pc_next    = redirect_pc_reg;

    case (state_reg)
      SLOT_EMPTY: if (accept) state_next = SLOT_FULL;
      SLOT_FULL:  if (!accept && bus.out_ready) state_next = SLOT_EMPTY;
      default:    state_next = SLOT_EMPTY;
    endcase

    if (bus.flush) begin
      state_next = SLOT_EMPTY;
    end

    // The redirect is raised only on the accepting edge, so a stalled
    // slot can never re-issue it.
    if (accept) begin
      slot_next = exec_slot;
      if (br_taken) begin
        redirect_valid_next = 1'b1;
        redirect_pc_next    = br_target;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg          <= SLOT_EMPTY;
      slot_reg           <= '0;
      redirect_valid_reg <= 1'b0;
      redirect_pc_reg    <= '0;
    end else begin
      state_reg          <= state_next;
      slot_reg           <= slot_next;
      redirect_valid_reg <= redirect_valid_next;
      redirect_pc_reg    <= redirect_pc_next;
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = (state_reg == SLOT_FULL);
  assign bus.out_result     = slot_reg.result;
  assign bus.out_store_data = slot_reg.store_data;
  assign bus.out_rd         = slot_reg.rd;
  assign bus.out_reg_write  = slot_reg.reg_write;
  assign bus.redirect_valid = redirect_valid_reg;
  assign bus.redirect_pc    = redirect_pc_reg;

endmodule

// File: tb/tb_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_stage -- self-checking bench for ex_stage.
// Directed vector table, hand-written stall/flush/reset sequences, then a
// randomized run checked against a transaction-level reference model.
// Honours EX_FORWARDING_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_ex_stage;

`ifdef EX_FORWARDING_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  logic clk;
  logic rst;

  ex_stage_if bus_if ();

  ex_stage #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic        a_pc;
    logic        b_imm;
    logic [2:0]  br;
    logic        jalr;
    logic [31:0] pc;
    logic [31:0] rs1v;
    logic [31:0] rs2v;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        regw;
    logic        mwe;
    logic [4:0]  mrd;
    logic [31:0] mdata;
    logic        wwe;
    logic [4:0]  wrd;
    logic [31:0] wdata;
  } instr_t;

  typedef struct {
    string       name;
    instr_t      in;
    logic [31:0] exp_result;
    logic        exp_rw;
    logic        exp_redir;
    logic [31:0] exp_rpc;
  } vec_t;

  typedef struct {
    logic [31:0] result;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rw;
    logic        taken;
    logic [31:0] target;
  } exp_t;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: instruction semantics from the ISA rules.
  // ---------------------------------------------------------------------
  function automatic logic [31:0] src_val(input logic [4:0] rs, input logic [31:0] rf, input instr_t i);
    if (FWD_ON && rs != 0 && i.mwe && i.mrd == rs) return i.mdata;
    if (FWD_ON && rs != 0 && i.wwe && i.wrd == rs) return i.wdata;
    return rf;
  endfunction

  // Signed less-than via sign-bit flip onto unsigned order.
  function automatic logic slt(input logic [31:0] a, input logic [31:0] b);
    return (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
  endfunction

  function automatic exp_t ref_exec(input instr_t i);
    exp_t e;
    logic [31:0] ra, rb, a, b;
    logic [63:0] ext;
    int sh;
    ra = src_val(i.rs1, i.rs1v, i);
    rb = src_val(i.rs2, i.rs2v, i);
    a  = i.a_pc  ? i.pc  : ra;
    b  = i.b_imm ? i.imm : rb;
    sh = int'(b % 32);
    case (i.op)
      4'd0: e.result = a + b;
      4'd1: e.result = a + ~b + 32'd1;
      4'd2: e.result = a << sh;
      4'd3: e.result = {31'd0, slt(a, b)};
      4'd4: e.result = {31'd0, a < b};
      4'd5: e.result = a ^ b;
      4'd6: e.result = a >> sh;
      4'd7: begin
        ext = {{32{a[31]}}, a} >> sh;
        e.result = ext[31:0];
      end
      4'd8: e.result = a | b;
      4'd9: e.result = a & b;
      default: e.result = 32'd0;
    endcase
    case (i.br)
      3'd1: e.taken = (ra == rb);
      3'd2: e.taken = (ra != rb);
      3'd3: e.taken = slt(ra, rb);
      3'd4: e.taken = !slt(ra, rb);
      3'd5: e.taken = (ra < rb);
      3'd6: e.taken = !(ra < rb);
      3'd7: e.taken = 1'b1;
      default: e.taken = 1'b0;
    endcase
    if (i.br == 3'd7) e.result = i.pc + 32'd4;
    e.target = i.jalr ? ((ra + i.imm) & 32'hFFFF_FFFE) : (i.pc + i.imm);
    e.sd = rb;
    e.rd = i.rd;
    e.rw = i.regw && (i.rd != 0);
    return e;
  endfunction

  // ---------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------
  function automatic instr_t base_instr();
    instr_t i;
    i.op = 4'd0; i.a_pc = 0; i.b_imm = 0; i.br = 3'd0; i.jalr = 0;
    i.pc = 32'h0; i.rs1v = 32'h0; i.rs2v = 32'h0; i.imm = 32'h0;
    i.rs1 = 5'd1; i.rs2 = 5'd2; i.rd = 5'd5; i.regw = 1'b1;
    i.mwe = 0; i.mrd = 5'd0; i.mdata = 32'h0;
    i.wwe = 0; i.wrd = 5'd0; i.wdata = 32'h0;
    return i;
  endfunction

  task automatic drive(input instr_t i);
    bus_if.in_alu_op    = i.op;
    bus_if.in_a_pc      = i.a_pc;
    bus_if.in_b_imm     = i.b_imm;
    bus_if.in_br_type   = i.br;
    bus_if.in_jalr      = i.jalr;
    bus_if.in_pc        = i.pc;
    bus_if.in_rs1_val   = i.rs1v;
    bus_if.in_rs2_val   = i.rs2v;
    bus_if.in_imm       = i.imm;
    bus_if.in_rs1       = i.rs1;
    bus_if.in_rs2       = i.rs2;
    bus_if.in_rd        = i.rd;
    bus_if.in_reg_write = i.regw;
    bus_if.fwd_mem_we   = i.mwe;
    bus_if.fwd_mem_rd   = i.mrd;
    bus_if.fwd_mem_data = i.mdata;
    bus_if.fwd_wb_we    = i.wwe;
    bus_if.fwd_wb_rd    = i.wrd;
    bus_if.fwd_wb_data  = i.wdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic instr_t rand_instr();
    instr_t i;
    i = base_instr();
    i.op    = 4'($urandom_range(0, 11));
    i.a_pc  = 1'($urandom_range(0, 3) == 0);
    i.b_imm = 1'($urandom_range(0, 1));
    i.br    = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
    i.jalr  = (i.br == 3'd7) ? 1'($urandom_range(0, 1)) : 1'b0;
    i.pc    = $urandom & 32'hFFFF_FFFC;
    i.rs1v  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
    i.rs2v  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
    i.imm   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 31)) : $urandom;
    i.rs1   = 5'($urandom_range(0, 3));
    i.rs2   = 5'($urandom_range(0, 3));
    i.rd    = 5'($urandom_range(0, 3));
    i.regw  = 1'($urandom_range(0, 1));
    i.mwe   = 1'($urandom_range(0, 1));
    i.mrd   = 5'($urandom_range(0, 3));
    i.mdata = $urandom;
    i.wwe   = 1'($urandom_range(0, 1));
    i.wrd   = 5'($urandom_range(0, 3));
    i.wdata = $urandom;
    return i;
  endfunction

  vec_t   vecs[$];
  vec_t   v;
  instr_t ins;
  exp_t   e;
  logic   m_valid, m_redir, exp_ready, acc;
  exp_t   m_slot;
  logic [31:0] m_rpc;
  logic [31:0] held_res, held_rpc;

  initial begin
    // ---------------- Vector table ----------------
    ins = base_instr(); ins.rs1v = 32'd5; ins.rs2v = 32'd7;
    vecs.push_back('{"add", ins, 32'd12, 1'b1, 1'b0, 32'h0});
    ins = base_instr(); ins.op = 4'd1; ins.rs1v = 32'd5; ins.rs2v = 32'd7;
    vecs.push_back('{"sub", ins, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'h0});
    ins = base_instr(); ins.op = 4'd7; ins.rs1v = 32'h8000_0000; ins.imm = 32'd4; ins.b_imm = 1;
    vecs.push_back('{"sra", ins, 32'hF800_0000, 1'b1, 1'b0, 32'h0});
    ins = base_instr(); ins.op = 4'd4; ins.rs1v = 32'd1; ins.rs2v = 32'hFFFF_FFFF;
    vecs.push_back('{"sltu", ins, 32'd1, 1'b1, 1'b0, 32'h0});
    ins = base_instr(); ins.op = 4'd3; ins.rs1v = 32'hFFFF_FFFF; ins.rs2v = 32'd1;
    vecs.push_back('{"slt", ins, 32'd1, 1'b1, 1'b0, 32'h0});
    ins = base_instr(); ins.regw = 0; ins.pc = 32'h100; ins.rs1v = 32'hFFFF_FFFF;
    ins.rs2v = 32'h0; ins.imm = 32'h20; ins.br = 3'd3;
    vecs.push_back('{"blt", ins, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h120});
    ins.br = 3'd5;
    vecs.push_back('{"bltu", ins, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0});
    ins = base_instr(); ins.pc = 32'h40; ins.rs1v = 32'h1001; ins.imm = 32'd2;
    ins.b_imm = 1; ins.br = 3'd7; ins.jalr = 1;
    vecs.push_back('{"jalr", ins, 32'h44, 1'b1, 1'b1, 32'h1002});
    ins = base_instr(); ins.pc = 32'hFFFF_FFFC; ins.imm = 32'd8; ins.a_pc = 1;
    ins.b_imm = 1; ins.br = 3'd7;
    vecs.push_back('{"jal_wrap", ins, 32'h0, 1'b1, 1'b1, 32'h4});
    ins = base_instr(); ins.rd = 5'd0; ins.rs1v = 32'd3; ins.rs2v = 32'd4;
    vecs.push_back('{"rd0", ins, 32'd7, 1'b0, 1'b0, 32'h0});
    ins = base_instr(); ins.op = 4'd12; ins.rs1v = 32'd3; ins.rs2v = 32'd4;
    vecs.push_back('{"badop", ins, 32'd0, 1'b1, 1'b0, 32'h0});
    ins = base_instr(); ins.br = 3'd1; ins.rs1v = 32'd9; ins.rs2v = 32'd9;
    ins.pc = 32'h200; ins.imm = 32'hFFFF_FFF0;
    vecs.push_back('{"beq", ins, 32'd18, 1'b1, 1'b1, 32'h1F0});
    ins = base_instr(); ins.br = 3'd4; ins.rs1v = 32'd0; ins.rs2v = 32'hFFFF_FFFF; ins.imm = 32'd8;
    vecs.push_back('{"bge", ins, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h8});
    ins = base_instr(); ins.rs1 = 5'd3; ins.rs1v = 32'h30; ins.b_imm = 1; ins.imm = 32'd1;
    ins.mwe = 1; ins.mrd = 5'd3; ins.mdata = 32'h10; ins.wwe = 1; ins.wrd = 5'd3; ins.wdata = 32'h20;
    vecs.push_back('{"fwd_mem", ins, FWD_ON ? 32'h11 : 32'h31, 1'b1, 1'b0, 32'h0});
    ins.mrd = 5'd4;
    vecs.push_back('{"fwd_wb", ins, FWD_ON ? 32'h21 : 32'h31, 1'b1, 1'b0, 32'h0});
    ins.rs1 = 5'd0; ins.mrd = 5'd0; ins.wrd = 5'd0;
    vecs.push_back('{"fwd_x0", ins, 32'h31, 1'b1, 1'b0, 32'h0});

    // ---------------- Reset ----------------
    rst = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    bus_if.flush     = 1'b0;
    drive(base_instr());
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
    check("rst_out_result", bus_if.out_result, 32'd0);
    check("rst_out_store_data", bus_if.out_store_data, 32'd0);
    check("rst_out_rd", 32'(bus_if.out_rd), 32'd0);
    check("rst_redirect_valid", 32'(bus_if.redirect_valid), 32'd0);
    check("rst_redirect_pc", bus_if.redirect_pc, 32'd0);
    rst = 1'b0;
    tick();
    check("idle_in_ready", 32'(bus_if.in_ready), 32'd1);

    // ---------------- Table, back-to-back ----------------
    foreach (vecs[k]) begin
      v = vecs[k];
      drive(v.in);
      bus_if.in_valid = 1'b1;
      tick();
      $display("[TB] vec %-9s result=%h redir=%0d rpc=%h", v.name,
               bus_if.out_result, bus_if.redirect_valid, bus_if.redirect_pc);
      check({v.name, ".out_valid"}, 32'(bus_if.out_valid), 32'd1);
      check({v.name, ".out_result"}, bus_if.out_result, v.exp_result);
      check({v.name, ".out_reg_write"}, 32'(bus_if.out_reg_write), 32'(v.exp_rw));
      check({v.name, ".redirect_valid"}, 32'(bus_if.redirect_valid), 32'(v.exp_redir));
      if (v.exp_redir) check({v.name, ".redirect_pc"}, bus_if.redirect_pc, v.exp_rpc);
    end
    bus_if.in_valid = 1'b0;
    tick();
    check("drain_out_valid", 32'(bus_if.out_valid), 32'd0);
    check("drain_redirect", 32'(bus_if.redirect_valid), 32'd0);

    // ---------------- JALR under 3-cycle backpressure ----------------
    ins = base_instr(); ins.pc = 32'h40; ins.rs1v = 32'h1001; ins.imm = 32'd2;
    ins.b_imm = 1; ins.br = 3'd7; ins.jalr = 1;
    drive(ins);
    bus_if.in_valid  = 1'b1;
    bus_if.out_ready = 1'b0;
    tick();
    check("stall.first_redirect", 32'(bus_if.redirect_valid), 32'd1);
    check("stall.result", bus_if.out_result, 32'h44);
    held_res = bus_if.out_result;
    held_rpc = bus_if.redirect_pc;
    ins = base_instr(); ins.br = 3'd7; ins.pc = 32'h500;
    drive(ins);
    for (int c = 0; c < 3; c++) begin
      check("stall.in_ready", 32'(bus_if.in_ready), 32'd0);
      tick();
      $display("[TB] stall cycle %0d result=%h redir=%0d", c, bus_if.out_result, bus_if.redirect_valid);
      check("stall.out_valid", 32'(bus_if.out_valid), 32'd1);
      check("stall.hold_result", bus_if.out_result, held_res);
      check("stall.hold_rpc", bus_if.redirect_pc, held_rpc);
      check("stall.no_redirect", 32'(bus_if.redirect_valid), 32'd0);
    end
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    tick();
    check("stall.release", 32'(bus_if.out_valid), 32'd0);

    // ---------------- Flush while stalled ----------------
    ins = base_instr(); ins.rs1v = 32'd1; ins.rs2v = 32'd2;
    drive(ins);
    bus_if.in_valid  = 1'b1;
    bus_if.out_ready = 1'b0;
    tick();
    check("flush.loaded", 32'(bus_if.out_valid), 32'd1);
    ins = base_instr(); ins.br = 3'd7; ins.pc = 32'h800;
    drive(ins);
    tick();
    bus_if.flush = 1'b1;
    #1;
    check("flush.in_ready", 32'(bus_if.in_ready), 32'd0);
    tick();
    $display("[TB] flush out_valid=%0d redir=%0d", bus_if.out_valid, bus_if.redirect_valid);
    check("flush.out_valid", 32'(bus_if.out_valid), 32'd0);
    check("flush.no_redirect", 32'(bus_if.redirect_valid), 32'd0);
    bus_if.flush    = 1'b0;
    bus_if.in_valid = 1'b0;
    bus_if.out_ready = 1'b1;
    tick();
    check("flush.not_accepted", 32'(bus_if.out_valid), 32'd0);

    // ---------------- Asynchronous reset mid-stream ----------------
    ins = base_instr(); ins.br = 3'd7; ins.pc = 32'h900; ins.imm = 32'h10; ins.rs1v = 32'd3;
    drive(ins);
    bus_if.in_valid  = 1'b1;
    bus_if.out_ready = 1'b0;
    tick();
    check("arst.pre_valid", 32'(bus_if.out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    $display("[TB] async reset out_valid=%0d result=%h", bus_if.out_valid, bus_if.out_result);
    check("arst.out_valid", 32'(bus_if.out_valid), 32'd0);
    check("arst.out_result", bus_if.out_result, 32'd0);
    check("arst.out_rd", 32'(bus_if.out_rd), 32'd0);
    check("arst.out_reg_write", 32'(bus_if.out_reg_write), 32'd0);
    check("arst.redirect_valid", 32'(bus_if.redirect_valid), 32'd0);
    check("arst.redirect_pc", bus_if.redirect_pc, 32'd0);
    bus_if.in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("arst.after_valid", 32'(bus_if.out_valid), 32'd0);
    check("arst.after_redirect", 32'(bus_if.redirect_valid), 32'd0);

    // ---------------- Randomized run vs. model ----------------
    m_valid = 1'b0;
    m_redir = 1'b0;
    m_rpc   = 32'h0;
    m_slot  = '{32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0};
    for (int c = 0; c < 400; c++) begin
      ins = rand_instr();
      drive(ins);
      bus_if.in_valid  = 1'($urandom_range(0, 3) != 0);
      bus_if.out_ready = 1'($urandom_range(0, 3) != 0);
      bus_if.flush     = 1'($urandom_range(0, 15) == 0);
      #1;
      exp_ready = !bus_if.flush && (!m_valid || bus_if.out_ready);
      check("rnd.in_ready", 32'(bus_if.in_ready), 32'(exp_ready));
      acc = bus_if.in_valid && exp_ready;
      e = ref_exec(ins);
      if (bus_if.flush) m_valid = 1'b0;
      else if (acc) begin
        m_valid = 1'b1;
        m_slot  = e;
      end else if (bus_if.out_ready) m_valid = 1'b0;
      m_redir = acc && e.taken;
      if (m_redir) m_rpc = e.target;
      @(posedge clk);
      #1;
      if (acc) $display("[TB] rnd %0d op=%0d br=%0d result=%h redir=%0d",
                        c, ins.op, ins.br, bus_if.out_result, bus_if.redirect_valid);
      check("rnd.out_valid", 32'(bus_if.out_valid), 32'(m_valid));
      if (m_valid) begin
        check("rnd.out_result", bus_if.out_result, m_slot.result);
        check("rnd.out_store_data", bus_if.out_store_data, m_slot.sd);
        check("rnd.out_rd", 32'(bus_if.out_rd), 32'(m_slot.rd));
        check("rnd.out_reg_write", 32'(bus_if.out_reg_write), 32'(m_slot.rw));
      end
      check("rnd.redirect_valid", 32'(bus_if.redirect_valid), 32'(m_redir));
      if (m_redir) check("rnd.redirect_pc", bus_if.redirect_pc, m_rpc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
